// File: rtl/pc_fetch.sv
// pc_fetch: MIPS-C3 program counter and instruction-fetch sequencer with a one-entry hold buffer.
// Optional misaligned-target trap is enabled by defining PC_FETCH_ALIGN_CHECK_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic        addr_err_f
);
    typedef enum logic [1:0] {S_RESET, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        valid_q, valid_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        buf_v_q, buf_v_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        idle_q, idle_d;

    logic        misalign, req, ack_live, ack_use, redir_acc, has_tgt;
    logic [31:0] redir_tgt, next_tgt, pc_inc;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    assign misalign  = (state_q == S_ISSUE) && (pc_q[1:0] != 2'b00);
    assign redir_tgt = redirect_target;
`else
    assign misalign  = 1'b0;
    assign redir_tgt = redirect_target & ~32'h0000_0003;
`endif

    assign req       = ((state_q == S_ISSUE) && !misalign) || (state_q == S_WAIT);
    assign ack_live  = req && imem_ack;
    assign ack_use   = ack_live && !kill_q;
    // A killed request blocks redirects so the exception vector stays pending.
    assign redir_acc = redirect_valid && !stall_i && !exc_req && !kill_q;
    assign has_tgt   = redir_acc || pend_q;
    assign next_tgt  = redir_acc ? redir_tgt : tgt_q;
    assign pc_inc    = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        pend_d      = pend_q;
        tgt_d       = tgt_q;
        valid_d     = valid_q;
        pcf_d       = pcf_q;
        instr_d     = instr_q;
        err_d       = err_q;
        buf_v_d     = buf_v_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        idle_d      = idle_q;

        if (exc_req) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            buf_v_d = 1'b0;
            idle_d  = 1'b0;
            if (req && !imem_ack) begin
                kill_d  = 1'b1;
                pend_d  = 1'b1;
                tgt_d   = EXC_VECTOR;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                pend_d  = 1'b0;
                pc_d    = EXC_VECTOR;
                state_d = S_ISSUE;
            end
        end else begin
            if (!stall_i) begin
                if (buf_v_q) begin
                    valid_d = 1'b1;
                    pcf_d   = buf_pc_q;
                    instr_d = buf_instr_q;
                    err_d   = 1'b0;
                    buf_v_d = 1'b0;
                end else if (ack_use) begin
                    valid_d = 1'b1;
                    pcf_d   = pc_q;
                    instr_d = imem_rdata;
                    err_d   = 1'b0;
                end else if (misalign && !idle_q) begin
                    valid_d = 1'b1;
                    pcf_d   = pc_q;
                    instr_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    idle_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
            end else if (ack_use) begin
                buf_v_d     = 1'b1;
                buf_pc_d    = pc_q;
                buf_instr_d = imem_rdata;
            end

            case (state_q)
                S_RESET: state_d = S_ISSUE;
                S_ISSUE, S_WAIT: begin
                    if (ack_live) begin
                        pc_d    = has_tgt ? next_tgt : pc_inc;
                        pend_d  = 1'b0;
                        kill_d  = 1'b0;
                        state_d = (stall_i && !kill_q) ? S_HOLD : S_ISSUE;
                    end else if (req) begin
                        state_d = S_WAIT;
                        if (redir_acc) begin
                            pend_d = 1'b1;
                            tgt_d  = redir_tgt;
                        end
                    end
                end
                S_HOLD: begin
                    if (redir_acc) pc_d = redir_tgt;
                    if (!stall_i) state_d = S_ISSUE;
                end
                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            pend_q      <= 1'b0;
            tgt_q       <= 32'h0;
            valid_q     <= 1'b0;
            pcf_q       <= 32'h0;
            instr_q     <= 32'h0;
            err_q       <= 1'b0;
            buf_v_q     <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= 32'h0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            pend_q      <= pend_d;
            tgt_q       <= tgt_d;
            valid_q     <= valid_d;
            pcf_q       <= pcf_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            buf_v_q     <= buf_v_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            idle_q      <= idle_d;
        end
    end

    assign imem_req   = req;
    assign imem_addr  = pc_q;
    assign valid_f    = valid_q;
    assign pc_f       = pcf_q;
    assign instr_f    = instr_q;
    assign addr_err_f = err_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; memory model returns the request address as data after w wait cycles.
module tb_pc_fetch;
    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid_f;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        addr_err_f;

    int checks = 0;
    int errors = 0;
    int w = 0;
    int cnt = 0;
    logic ack_force = 1'b0;

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_req(exc_req), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid_f(valid_f),
        .pc_f(pc_f), .instr_f(instr_f), .addr_err_f(addr_err_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ack on the w-th cycle of a continuously asserted request (w=0: same cycle).
    assign imem_ack   = ack_force || (imem_req && (cnt == w));
    assign imem_rdata = imem_addr;
    always @(posedge clk) begin
        if (!imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        stall_i = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        exc_req = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'hBFC0_0000);
        chk("rst_valid", {31'h0, valid_f}, 32'h0);
        chk("rst_pc_f", pc_f, 32'h0);
        chk("rst_instr", instr_f, 32'h0);
        chk("rst_err", {31'h0, addr_err_f}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // zero-wait streaming
        step();
        chk("c1_req", {31'h0, imem_req}, 32'h1);
        chk("c1_addr", imem_addr, 32'hBFC0_0000);
        chk("c1_valid", {31'h0, valid_f}, 32'h0);
        step();
        chk("c2_addr", imem_addr, 32'hBFC0_0004);
        chk("c2_valid", {31'h0, valid_f}, 32'h1);
        chk("c2_instr", instr_f, 32'hBFC0_0000);
        chk("c2_pc_f", pc_f, 32'hBFC0_0000);
        step();
        chk("c3_addr", imem_addr, 32'hBFC0_0008);
        chk("c3_instr", instr_f, 32'hBFC0_0004);
        chk("c3_valid", {31'h0, valid_f}, 32'h1);

        // two-cycle latency with a 3-cycle stall
        step();
        w = 1;
        stall_i = 1'b1;
        chk("c4_addr", imem_addr, 32'hBFC0_000C);
        chk("c4_instr", instr_f, 32'hBFC0_0008);
        step();
        chk("c5_ack", {31'h0, imem_ack}, 32'h1);
        chk("c5_instr_held", instr_f, 32'hBFC0_0008);
        chk("c5_valid_held", {31'h0, valid_f}, 32'h1);
        step();
        chk("c6_req_buf_full", {31'h0, imem_req}, 32'h0);
        chk("c6_instr_held", instr_f, 32'hBFC0_0008);
        step();
        stall_i = 1'b0;
        chk("c7_req_buf_full", {31'h0, imem_req}, 32'h0);
        chk("c7_instr_held", instr_f, 32'hBFC0_0008);

        // redirect while BFC00010 is in flight
        step();
        chk("c8_instr_drain", instr_f, 32'hBFC0_000C);
        chk("c8_valid", {31'h0, valid_f}, 32'h1);
        chk("c8_addr", imem_addr, 32'hBFC0_0010);
        redirect_valid = 1'b1;
        redirect_target = 32'h0040_0100;
        step();
        redirect_valid = 1'b0;
        chk("c9_addr_held", imem_addr, 32'hBFC0_0010);
        chk("c9_valid", {31'h0, valid_f}, 32'h0);
        step();
        chk("c10_delay_slot", instr_f, 32'hBFC0_0010);
        chk("c10_addr_target", imem_addr, 32'h0040_0100);
        step();
        chk("c11_addr", imem_addr, 32'h0040_0100);
        step();
        chk("c12_instr_target", instr_f, 32'h0040_0100);
        chk("c12_addr", imem_addr, 32'h0040_0104);
        w = 2;

        // exception during WAIT
        step();
        chk("c13_ack_pending", {31'h0, imem_ack}, 32'h0);
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        chk("c14_valid_cleared", {31'h0, valid_f}, 32'h0);
        chk("c14_addr_held", imem_addr, 32'h0040_0104);
        chk("c14_killed_ack", {31'h0, imem_ack}, 32'h1);
        step();
        w = 0;
        chk("c15_addr_exc", imem_addr, 32'hBFC0_0380);
        chk("c15_no_stale", {31'h0, valid_f}, 32'h0);
        step();
        chk("c16_instr_exc", instr_f, 32'hBFC0_0380);
        chk("c16_valid", {31'h0, valid_f}, 32'h1);
        chk("c16_addr", imem_addr, 32'hBFC0_0384);

        // exception and redirect together
        exc_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        exc_req = 1'b0;
        redirect_valid = 1'b0;
        chk("c17_valid", {31'h0, valid_f}, 32'h0);
        chk("c17_addr_exc", imem_addr, 32'hBFC0_0380);
        step();
        chk("c18_addr_no_redir", imem_addr, 32'hBFC0_0384);

        // wrap from FFFFFFFC
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("c19_addr", imem_addr, 32'hFFFF_FFFC);
        chk("c19_delay_slot", instr_f, 32'hBFC0_0384);
        step();
        chk("c20_wrap", imem_addr, 32'h0000_0000);
        chk("c20_instr", instr_f, 32'hFFFF_FFFC);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_target = 32'h0040_0102;
        step();
        redirect_valid = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        chk("al_req_off", {31'h0, imem_req}, 32'h0);
        step();
        chk("al_err", {31'h0, addr_err_f}, 32'h1);
        chk("al_valid", {31'h0, valid_f}, 32'h1);
        chk("al_pc_f", pc_f, 32'h0040_0102);
        chk("al_instr_nop", instr_f, 32'h0);
        chk("al_req_idle", {31'h0, imem_req}, 32'h0);
        step();
        chk("al_err_one_slot", {31'h0, addr_err_f}, 32'h0);
        chk("al_still_idle", {31'h0, imem_req}, 32'h0);
`else
        chk("al_addr_masked", imem_addr, 32'h0040_0100);
        chk("al_req", {31'h0, imem_req}, 32'h1);
        step();
        chk("al_instr", instr_f, 32'h0040_0100);
        chk("al_err_zero", {31'h0, addr_err_f}, 32'h0);
`endif

        // async reset mid-stream, late ack while in reset state
        rst_n = 1'b0;
        #1;
        chk("mr_req", {31'h0, imem_req}, 32'h0);
        chk("mr_addr", imem_addr, 32'hBFC0_0000);
        chk("mr_valid", {31'h0, valid_f}, 32'h0);
        ack_force = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        step();
        ack_force = 1'b0;
        chk("mr_late_ack_ignored", {31'h0, valid_f}, 32'h0);
        chk("mr_req_after", {31'h0, imem_req}, 32'h1);
        chk("mr_addr_after", imem_addr, 32'hBFC0_0000);
        step();
        chk("mr_first_instr", instr_f, 32'hBFC0_0000);
        chk("mr_next_addr", imem_addr, 32'hBFC0_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the MIPS-C3 core. It consumes the next-PC target produced in decode (`redirect_valid`/`redirect_target`) and the exception request. It drives a request/acknowledge instruction-memory port and delivers `{pc_f, instr_f, valid_f}` into the IF/ID register. MIPS branch-delay-slot semantics are enforced at fetch: the one instruction already requested when a redirect arrives is kept, and fetch continues at the target.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset.
- `EXC_VECTOR`, 32'hBFC0_0380, fetch address on `exc_req`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hazard unit: IF/ID must hold its contents.
- `redirect_valid`  in  1  taken branch/jump resolved in decode this cycle.
- `redirect_target`  in  32  target for `redirect_valid`.
- `exc_req`  in  1  exception/flush: restart at `EXC_VECTOR`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of request.
- `imem_ack`  in  1  response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction, valid when `imem_ack`=1.
- `valid_f`  out  1  `instr_f`/`pc_f` hold a live instruction.
- `pc_f`  out  32  PC of `instr_f`.
- `instr_f`  out  32  fetched instruction.
- `addr_err_f`  out  1  misaligned fetch target (see Configuration).

## Operation
- States: RESET, ISSUE, WAIT, HOLD.
  - RESET: entered on `rst_n`=0. Leaves to ISSUE on the first edge after deassertion.
  - ISSUE: `imem_req`=1 with `imem_addr`=pc.
    - `imem_ack` in the same cycle: data captured, stay in ISSUE with pc+4.
    - No ack: go to WAIT.
  - WAIT: `imem_req` and `imem_addr` held stable until `imem_ack`.
  - HOLD: the output register and the one-entry hold buffer are both occupied. No request is issued. Returns to ISSUE when `stall_i`=0 and the buffer drains.
- Delivery:
  - On ack with `stall_i`=0, the instruction loads the output register.
  - On ack with `stall_i`=1, it loads the hold buffer.
  - The buffer empties into the output register on the first cycle `stall_i`=0.
  - A new request is never issued while the buffer is full, so at most one request is outstanding.
- Next-PC priority: `exc_req` > `redirect_valid` > pc+4.
- Redirect:
  - `redirect_target` is latched as pending.
  - An instruction already requested, in flight, or buffered is the delay slot. It is delivered normally.
  - The next issued request uses the target.
  - `redirect_valid` is honoured only when `stall_i`=0 and ignored otherwise; decode re-presents it.
  - A second redirect before the pending one issues overwrites the target.
- Exception:
  - Clears `valid_f` and the buffer at the next edge. pc becomes `EXC_VECTOR`.
  - An outstanding request sets a kill flag. Its ack is consumed and discarded, then `EXC_VECTOR` is issued.
  - `exc_req` with `redirect_valid` in the same cycle: the redirect is dropped.
- Arithmetic: pc+4 is a 32-bit add that wraps at 32'hFFFF_FFFC to 0. No carry is kept.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `valid_f`=0, `pc_f`=0, `instr_f`=0, `addr_err_f`=0. The buffer is empty, the kill flag is clear, and pending redirect is none.
- First `imem_req` asserts in the first cycle after `rst_n` rises.
- Latency: ack in cycle N gives `valid_f`=1 with the data in cycle N+1.
  - Zero-wait memory sustains one instruction per cycle.
- Redirect in cycle N with no outstanding request: the target is issued in cycle N+1.
  - If a request is outstanding, the target issues the cycle after its ack.
- `exc_req` in cycle N: `valid_f`=0 in N+1. `EXC_VECTOR` issues in N+1, or after the killed ack.
- `rst_n` low mid-request: all state is cleared asynchronously. A late ack after reset is ignored because `imem_req` is 0.
- While `stall_i`=1, `valid_f`, `pc_f` and `instr_f` are unchanged.

## Configuration
- `PC_FETCH_ALIGN_CHECK_EN` defined:
  - A pending or exception target with bits [1:0]≠0 is not requested.
  - It is delivered as `valid_f`=1, `pc_f`=target, `instr_f`=0 (NOP), `addr_err_f`=1 for one instruction slot.
  - Fetch then idles in ISSUE with `imem_req`=0 until `exc_req`.
- Undefined: bits [1:0] of every target are forced to 0, and `addr_err_f` is tied 0.

## Test plan
- Reset, zero-wait memory returning the address as data: `imem_addr` is BFC00000, BFC00004, BFC00008 on consecutive cycles. `instr_f` follows one cycle later and `valid_f` stays 1.
- Two-cycle memory latency with `stall_i`=1 for 3 cycles mid-stream: no instruction is lost or duplicated, `imem_req` stays low while the buffer is full, and order is preserved.
- `redirect_valid` with target 0x00400100 while 0xBFC00010 is in flight: 0xBFC00010 is delivered as the delay slot, then 0x00400100 is delivered and 0xBFC00014 is never requested.
- `exc_req` during WAIT: the returned word is discarded, `valid_f`=0 the next cycle, the next `imem_addr` is BFC00380, and no stale instruction appears.
- `exc_req` and `redirect_valid` in the same cycle: only `EXC_VECTOR` is fetched. Also check pc wrap from 0xFFFFFFFC to 0x00000000.
- Redirect to 0x00400102: with `PC_FETCH_ALIGN_CHECK_EN`, expect `addr_err_f`=1, `instr_f`=0 and no request. Without it, expect a fetch of 0x00400100.
